// File: rtl/shift_deser_pkg.sv
// Shared constants for the serial-to-parallel receiver: shift direction codes
// and the frame FSM state encoding.
package shift_deser_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in shift register with direction mux and bit counter.
// done_s is high during the cycle whose sampled bit completes the word.
module sipo_shift_core
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             sin,
    input  logic             dir,
    output logic [WIDTH-1:0] word_next,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_next_s;
    logic [CW-1:0]    bit_cnt_r;
    logic             done_s;

    // Next shift-register contents for the selected direction.
    always_comb begin
        sreg_next_s = sreg_r;
        if (shift_en) begin
            case (dir)
                DIR_MSB_FIRST: sreg_next_s = {sreg_r[WIDTH-2:0], sin};
                DIR_LSB_FIRST: sreg_next_s = {sin, sreg_r[WIDTH-1:1]};
                default:       sreg_next_s = sreg_r;
            endcase
        end else begin
            sreg_next_s = sreg_r;
        end
    end

    assign done_s    = shift_en && (bit_cnt_r == LAST_CNT);
    assign done      = done_s;
    assign word_next = sreg_next_s;

    // Shift register and bit counter; counter rolls to zero on the last bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_r    <= '0;
            bit_cnt_r <= '0;
        end else if (clear) begin
            sreg_r    <= '0;
            bit_cnt_r <= '0;
        end else if (shift_en) begin
            sreg_r    <= sreg_next_s;
            bit_cnt_r <= done_s ? '0 : bit_cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: frame FSM, valid/ready output register,
// sticky overrun flag and delivered-frame counter around sipo_shift_core.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);

    state_e           state_r;
    state_e           state_next_s;
    logic             dir_r;
    logic             dir_eff_s;
    logic             shift_en_s;
    logic             done_s;
    logic             accept_ok_s;
    logic             busy_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] pout_r;
    logic             pout_valid_r;
    logic             overrun_r;
    logic [CNT_W-1:0] frame_cnt_r;

    // A clear on the same edge discards the incoming bit.
    assign shift_en_s  = sin_valid && !clear;
    assign dir_eff_s   = (state_r == IDLE) ? dir : dir_r;
    assign accept_ok_s = !pout_valid_r || pout_ready;

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .shift_en  (shift_en_s),
        .sin       (sin),
        .dir       (dir_eff_s),
        .word_next (word_s),
        .done      (done_s)
    );

    // FSM state register and per-frame direction latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            dir_r   <= DIR_MSB_FIRST;
        end else begin
            state_r <= state_next_s;
            if (state_r == IDLE && shift_en_s) begin
                dir_r <= dir;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = (shift_en_s && !done_s) ? RECV : IDLE;
                RECV:    state_next_s = done_s ? IDLE : RECV;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            IDLE:    busy_s = 1'b0;
            RECV:    busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Output word, handshake, overrun and frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout_r       <= '0;
            pout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            frame_cnt_r  <= '0;
        end else if (clear) begin
            pout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (done_s) begin
            if (accept_ok_s) begin
                pout_r       <= word_s;
                pout_valid_r <= 1'b1;
                frame_cnt_r  <= frame_cnt_r + CNT_W'(1);
            end else begin
                overrun_r    <= 1'b1;
            end
        end else if (pout_valid_r && pout_ready) begin
            pout_valid_r <= 1'b0;
        end
    end

    assign pout       = pout_r;
    assign pout_valid = pout_valid_r;
    assign busy       = busy_s;
    assign overrun    = overrun_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus a
// scoreboard of expected words popped whenever a new frame is delivered.
module tb_shift_deserializer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             sin;
    logic             sin_valid;
    logic             dir;
    logic             clear;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;
    logic [CNT_W-1:0] frame_cnt;

    int n_vec;
    int n_err;
    int exp_cnt;
    logic [WIDTH-1:0] sb_q [$];

    shift_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dir        (dir),
        .clear      (clear),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected parallel word for bits sent in order b[3], b[2], b[1], b[0].
    function automatic logic [WIDTH-1:0] model_word(input logic [WIDTH-1:0] b, input logic d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d ? b[WIDTH-1-i] : b[i];
        end
        return r;
    endfunction

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic d);
        sin       = b;
        sin_valid = 1'b1;
        dir       = d;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] b, input logic d, input bit push);
        if (push) begin
            sb_q.push_back(model_word(b, d));
            exp_cnt = (exp_cnt + 1) % 256;
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(b[i], d);
        end
    endtask

    // Monitor: each frame_cnt step of +1 means a delivered word to compare.
    logic [CNT_W-1:0] mon_last;
    initial mon_last = '0;
    always @(posedge clk) begin
        #2;
        if (frame_cnt == mon_last + 8'd1) begin
            if (sb_q.size() == 0) begin
                chk_val("sb_unexpected", 32'(pout), 32'hFFFF_FFFF);
            end else begin
                chk_val("sb_pout", 32'(pout), 32'(sb_q.pop_front()));
            end
        end
        mon_last = frame_cnt;
    end

    initial begin
        n_vec = 0; n_err = 0; exp_cnt = 0;
        rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0;
        clear = 1'b0; pout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_pout", 32'(pout), 32'd0);
        chk_val("rst_valid", 32'(pout_valid), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_overrun", 32'(overrun), 32'd0);
        chk_val("rst_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b1;
        idle_cycle();

        // MSB-first
        pout_ready = 1'b1;
        sb_q.push_back(4'b1011); exp_cnt = 1;
        send_bit(1'b1, 1'b0);
        chk_val("msb_busy_mid", 32'(busy), 32'd1);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk_val("msb_pout", 32'(pout), 32'hB);
        chk_val("msb_valid", 32'(pout_valid), 32'd1);
        chk_val("msb_cnt", 32'(frame_cnt), 32'd1);
        chk_val("msb_busy_end", 32'(busy), 32'd0);
        idle_cycle();
        chk_val("msb_accepted", 32'(pout_valid), 32'd0);
        chk_val("msb_hold", 32'(pout), 32'hB);

        // LSB-first with dir toggled after the first bit
        sb_q.push_back(4'b1101); exp_cnt = 2;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
        chk_val("lsb_pout", 32'(pout), 32'hD);
        idle_cycle();

        // Overrun with stalled consumer
        pout_ready = 1'b0;
        send_word(4'b0011, 1'b0, 1'b1);
        send_word(4'b0101, 1'b0, 1'b0);
        chk_val("ovr_pout", 32'(pout), 32'h3);
        chk_val("ovr_flag", 32'(overrun), 32'd1);
        chk_val("ovr_cnt", 32'(frame_cnt), 32'(exp_cnt));
        idle_cycle();
        chk_val("ovr_sticky", 32'(overrun), 32'd1);
        clear = 1'b1;
        idle_cycle();
        clear = 1'b0;
        chk_val("clr_overrun", 32'(overrun), 32'd0);
        chk_val("clr_valid", 32'(pout_valid), 32'd0);
        chk_val("clr_pout", 32'(pout), 32'h3);
        chk_val("clr_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Accept and completion on the same edge
        send_word(4'b0001, 1'b0, 1'b1);
        sb_q.push_back(4'b1110); exp_cnt++;
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        pout_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        chk_val("sim_pout", 32'(pout), 32'hE);
        chk_val("sim_valid", 32'(pout_valid), 32'd1);
        chk_val("sim_overrun", 32'(overrun), 32'd0);
        chk_val("sim_cnt", 32'(frame_cnt), 32'(exp_cnt));
        idle_cycle();

        // Asynchronous reset mid-frame
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_val("arst_busy", 32'(busy), 32'd0);
        chk_val("arst_cnt", 32'(frame_cnt), 32'd0);
        #1 rst = 1'b1;
        exp_cnt = 0;
        idle_cycle();
        send_word(4'b0110, 1'b0, 1'b1);
        chk_val("arst_pout", 32'(pout), 32'h6);
        chk_val("arst_cnt2", 32'(frame_cnt), 32'd1);

        // Stall with gaps, then clear coincident with a valid bit
        send_bit(1'b1, 1'b0); idle_cycle(); idle_cycle();
        chk_val("stall_busy", 32'(busy), 32'd1);
        send_bit(1'b0, 1'b0); idle_cycle();
        send_bit(1'b1, 1'b0);
        clear = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        idle_cycle();
        clear = 1'b0; sin_valid = 1'b0;
        chk_val("stclr_busy", 32'(busy), 32'd0);
        send_word(4'b1001, 1'b0, 1'b1);
        chk_val("stclr_pout", 32'(pout), 32'h9);
        chk_val("stclr_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Back-to-back random frames, long enough to wrap frame_cnt
        for (int k = 0; k < 260; k++) begin
            send_word(WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
        end
        idle_cycle();
        chk_val("wrap_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk_val("wrap_overrun", 32'(overrun), 32'd0);
        chk_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
